// File: rtl/uart_imem_loader_pkg.sv
// Package for the UART instruction-memory boot loader.
// Holds the loader FSM state encoding and the default constants shared by
// the top module and its timeout sub-module.
package loader_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DONE  = 2'd1,
        ERROR = 2'd2
    } loader_state_t;

    // The end-of-program marker is this byte repeated across the whole word.
    localparam logic [7:0] END_BYTE = 8'hFF;

    // Maximum idle clk cycles allowed between two bytes of the same word.
    localparam int DEFAULT_TIMEOUT_CYC = 200000;

endpackage

// File: rtl/uart_imem_loader_if.sv
// Bus bundle between the UART receiver, the boot loader and instruction memory.
// Ports:
//   rx_valid  one-cycle strobe, rx_data holds a new byte
//   rx_data   received byte
//   rx_break  UART BREAK detected
//   mem_we    imem write enable, one-cycle pulse
//   mem_addr  imem write address
//   mem_wdata imem write data
// Handshake: neither direction has a ready signal. A byte is transferred in
// every cycle where rx_valid=1, and a word is written in every cycle where
// mem_we=1; the loader never stalls the receiver and memory always accepts.
// Modports: master = UART/memory side, slave = loader.
interface uart_imem_loader_if #(
    parameter int WORD_BYTES = 4,
    parameter int ADDR_W     = 5
);
    logic                    rx_valid;
    logic [7:0]              rx_data;
    logic                    rx_break;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [8*WORD_BYTES-1:0] mem_wdata;

    modport master (
        output rx_valid, rx_data, rx_break,
        input  mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  rx_valid, rx_data, rx_break,
        output mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/uart_imem_loader_timeout.sv
// Idle-cycle counter for the boot loader.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   clear     zero the counter (takes priority over enable)
//   enable    count this cycle as idle
//   hit       the current enabled cycle is the TIMEOUT_CYC-th idle cycle
module loader_timeout #(
    parameter int TIMEOUT_CYC = loader_pkg::DEFAULT_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic hit
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // cnt_q holds the number of idle cycles already completed, so the
    // TIMEOUT_CYC-th idle cycle is the one that sees TIMEOUT_CYC-1.
    assign hit = enable && (cnt_q == CW'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/uart_imem_loader.sv
// UART boot loader: packs received bytes (first byte = LSB) into instruction
// words and writes them to consecutive imem addresses, holding the core in
// reset until an end-marker run or a full memory finishes the load.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   bus          rx byte stream in, imem write port out (slave modport)
//   core_rst     core reset, high until DONE
//   write_done   sticky, end sequence received
//   word_count   words written so far
//   err_break    sticky, BREAK aborted the load
//   err_timeout  sticky, a partial word was dropped on inter-byte timeout
//   full         sticky, DEPTH words written without end sequence
//   state_o      current FSM state (debug)
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int                    WORD_BYTES  = 4,
    parameter int                    DEPTH       = 32,
    parameter int                    ADDR_W      = $clog2(DEPTH),
    parameter logic [8*WORD_BYTES-1:0] END_WORD  = {WORD_BYTES{END_BYTE}},
    parameter int                    END_REPEAT  = 2,
    parameter int                    TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_imem_loader_if.slave     bus,
    output logic                  core_rst,
    output logic                  write_done,
    output logic [ADDR_W:0]       word_count,
    output logic                  err_break,
    output logic                  err_timeout,
    output logic                  full,
    output loader_state_t         state_o
);
    localparam int W     = 8 * WORD_BYTES;
    localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int RUN_W = $clog2(END_REPEAT + 1);
    localparam int CNT_W = ADDR_W + 1;

    loader_state_t    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_eff;
    logic [W-1:0]     word_q, word_d, word_tmp;
    logic [W-1:0]     wdata_q, wdata_d;
    logic             pend_q, pend_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [RUN_W-1:0] run_q, run_d, run_inc;
    logic             write_done_q, write_done_d;
    logic             err_break_q, err_break_d;
    logic             err_timeout_q, err_timeout_d;
    logic             full_q, full_d;
    logic             to_hit, to_enable, to_clear, rx_accept;

    assign rx_accept = (state_q == LOAD) && bus.rx_valid && !bus.rx_break;
    assign to_enable = (state_q == LOAD) && (idx_q != '0);
    assign to_clear  = rx_accept || to_hit || !to_enable;

    loader_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (to_clear),
        .enable (to_enable),
        .hit    (to_hit)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        word_d        = word_q;
        wdata_d       = wdata_q;
        pend_d        = 1'b0;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        run_d         = run_q;
        write_done_d  = write_done_q;
        err_break_d   = err_break_q;
        err_timeout_d = err_timeout_q;
        full_d        = full_q;
        run_inc       = run_q + RUN_W'(1);
        // A timeout in the same cycle as a new byte makes that byte byte 0.
        idx_eff       = to_hit ? '0 : idx_q;
        word_tmp      = word_q;
        word_tmp[{idx_eff, 3'b000} +: 8] = bus.rx_data;

        if (state_q == LOAD) begin
            // Bookkeeping for the word being written this cycle.
            if (pend_q) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                count_d  = count_q + CNT_W'(1);
                if (wdata_q == END_WORD) begin
                    run_d = run_inc;
                end else begin
                    run_d = '0;
                end
                if ((wdata_q == END_WORD) && (run_inc == RUN_W'(END_REPEAT))) begin
                    write_done_d = 1'b1;
                    state_d      = DONE;
                end else if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                    full_d  = 1'b1;
                    state_d = DONE;
                end
            end

            if (bus.rx_break) begin
                state_d     = ERROR;
                err_break_d = 1'b1;
                idx_d       = '0;
            end else if (state_d == LOAD) begin
                if (to_hit) begin
                    idx_d         = '0;
                    err_timeout_d = 1'b1;
                end
                if (bus.rx_valid) begin
                    word_d = word_tmp;
                    if (idx_eff == IDX_W'(WORD_BYTES - 1)) begin
                        idx_d   = '0;
                        pend_d  = 1'b1;
                        wdata_d = word_tmp;
                    end else begin
                        idx_d = idx_eff + IDX_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= LOAD;
            idx_q         <= '0;
            word_q        <= '0;
            wdata_q       <= '0;
            pend_q        <= 1'b0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            run_q         <= '0;
            write_done_q  <= 1'b0;
            err_break_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            full_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            word_q        <= word_d;
            wdata_q       <= wdata_d;
            pend_q        <= pend_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            run_q         <= run_d;
            write_done_q  <= write_done_d;
            err_break_q   <= err_break_d;
            err_timeout_q <= err_timeout_d;
            full_q        <= full_d;
        end
    end

    assign bus.mem_we    = pend_q;
    assign bus.mem_addr  = wr_ptr_q;
    assign bus.mem_wdata = wdata_q;
    assign core_rst      = (state_q != DONE);
    assign write_done    = write_done_q;
    assign word_count    = count_q;
    assign err_break     = err_break_q;
    assign err_timeout   = err_timeout_q;
    assign full          = full_q;
    assign state_o       = state_q;
endmodule
